// File: rtl/printer_arbiter.sv
// printer_arbiter: round-robin sharing of one character printer among N_REQ requesters,
// driving the printer FGO/data handshake with an optional SEND timeout.
`default_nettype none

module printer_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req_in,
    input  logic [8*N_REQ-1:0] data_in,
    output logic [N_REQ-1:0]   grant_out,
    output logic [N_REQ-1:0]   done_out,
    output logic [7:0]         data_out,
    output logic               fgo_out,
    input  logic               clear_in,
    output logic               busy_out,
    output logic               error_out
);

    localparam int PW  = $clog2(N_REQ);
    localparam int PW1 = PW + 1;
    localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0]    CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0]    CNT_MAX  = '1;
    localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);
    localparam logic [PW1-1:0]   N_WIDE   = PW1'(N_REQ);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND  = 3'd1,
        ACK   = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_t;

    state_t            state, state_nx;
    logic [PW-1:0]     winner, winner_nx;
    logic [PW-1:0]     pointer, pointer_nx;
    logic [CW-1:0]     counter, counter_nx;
    logic [N_REQ-1:0]  grant_nx, done_nx;
    logic [7:0]        data_nx;
    logic              fgo_nx, busy_nx, error_nx;

    logic              found;
    logic [PW-1:0]     pick;
    logic [7:0]        pick_data;
    logic [PW1-1:0]    slot;
    logic [PW-1:0]     ptr_after;

    // Rotating priority search: slot walks pointer, pointer+1, ... modulo N_REQ.
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        pick_data = '0;
        slot      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            slot = {1'b0, pointer} + PW1'(i);
            if (slot >= N_WIDE) begin
                slot = slot - N_WIDE;
            end
            if (!found && req_in[slot[PW-1:0]]) begin
                found     = 1'b1;
                pick      = slot[PW-1:0];
                pick_data = data_in[{slot[PW-1:0], 3'b000} +: 8];
            end
        end
    end

    assign ptr_after = (winner == PW'(N_REQ - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        state_nx   = state;
        winner_nx  = winner;
        pointer_nx = pointer;
        counter_nx = counter;
        grant_nx   = grant_out;
        done_nx    = '0;
        data_nx    = data_out;
        fgo_nx     = fgo_out;
        error_nx   = 1'b0;
        case (state)
            IDLE: begin
                // A clear_in still high here is the tail of the previous ack, not a new one.
                if (found && !clear_in) begin
                    state_nx   = SEND;
                    winner_nx  = pick;
                    grant_nx   = ONE << pick;
                    data_nx    = pick_data;
                    fgo_nx     = 1'b0;
                    counter_nx = '0;
                end
            end
            SEND: begin
                counter_nx = (counter == CNT_MAX) ? counter : counter + 1'b1;
                if (clear_in) begin
                    state_nx = ACK;
                    fgo_nx   = 1'b1;
                end else if (TO_EN && counter == CNT_LAST) begin
                    state_nx   = ABORT;
                    fgo_nx     = 1'b1;
                    grant_nx   = '0;
                    error_nx   = 1'b1;
                    counter_nx = '0;
                end
            end
            ACK: begin
                if (!clear_in) begin
                    state_nx   = DONE;
                    done_nx    = ONE << winner;
                    grant_nx   = '0;
                    counter_nx = '0;
                end
            end
            DONE: begin
                state_nx   = IDLE;
                pointer_nx = ptr_after;
            end
            ABORT: begin
                state_nx   = IDLE;
                pointer_nx = ptr_after;
            end
            default: begin
                state_nx = IDLE;
                fgo_nx   = 1'b1;
                grant_nx = '0;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            winner    <= '0;
            pointer   <= '0;
            counter   <= '0;
            grant_out <= '0;
            done_out  <= '0;
            data_out  <= '0;
            fgo_out   <= 1'b1;
            busy_out  <= 1'b0;
            error_out <= 1'b0;
        end else begin
            state     <= state_nx;
            winner    <= winner_nx;
            pointer   <= pointer_nx;
            counter   <= counter_nx;
            grant_out <= grant_nx;
            done_out  <= done_nx;
            data_out  <= data_nx;
            fgo_out   <= fgo_nx;
            busy_out  <= busy_nx;
            error_out <= error_nx;
        end
    end

endmodule

`default_nettype wire
